// File: rtl/lwc_api_pkg.sv
// lwc_api_pkg: shared LWC output-side constants and the stored FIFO entry format
// Contents: LWC_W (byte width), ENTRY_W (byte plus last flag), STATUS_SUCCESS / STATUS_FAILURE
// status-byte codes, and entry_t (last flag packed above the data byte).
package lwc_api_pkg;
  localparam int LWC_W = 8;
  localparam int ENTRY_W = LWC_W + 1;
  localparam logic [LWC_W-1:0] STATUS_SUCCESS = 8'hE0;
  localparam logic [LWC_W-1:0] STATUS_FAILURE = 8'hF0;
  typedef struct packed {
    logic last;
    logic [LWC_W-1:0] data;
  } entry_t;
endpackage

// File: rtl/lwc_do_buffer_if.sv
// lwc_do_buffer_if: byte stream handshake (data, valid, last, ready)
// master drives data/valid/last and samples ready; slave does the reverse.
interface lwc_do_buffer_if;
  import lwc_api_pkg::*;
  logic [LWC_W-1:0] data;
  logic valid;
  logic last;
  logic ready;
  modport master(output data, valid, last, input ready);
  modport slave(input data, valid, last, output ready);
endinterface

// File: rtl/lwc_fifo_mem.sv
// lwc_fifo_mem: DEPTH x entry_t register array, one write port, async read
// Ports: clk, rst (async active-low, clears contents), we/waddr/wdata write port,
// raddr/rdata combinational read port.
module lwc_fifo_mem
  import lwc_api_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  entry_t        wdata,
  input  logic [AW-1:0] raddr,
  output entry_t        rdata
);
  entry_t mem [DEPTH];
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/lwc_do_buffer.sv
// lwc_do_buffer: elastic output FIFO between the LWC do_* stream and an external sink
// Ports: clk, rst (async active-low); din (slave: do_data/do_valid/do_last in, do_ready out);
// dout (master: out_data/out_valid/out_last out, out_ready in); level (occupancy 0..DEPTH);
// msg_cnt (messages delivered, wraps); auth_ok/auth_fail/proto_err (status pulses).
// Build option: define LWC_DO_STATUS_CHK_EN to decode the final byte of each delivered
// message; otherwise the three status outputs are tied low.
module lwc_do_buffer
  import lwc_api_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  lwc_do_buffer_if.slave  din,
  lwc_do_buffer_if.master dout,
  output logic [AW:0]   level,
  output logic [7:0]    msg_cnt,
  output logic          auth_ok,
  output logic          auth_fail,
  output logic          proto_err
);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] level_nxt;
  logic push, pop;
  entry_t wr_entry, rd_entry;
  assign push = din.valid & din.ready;
  assign pop = dout.valid & dout.ready;
  assign level_nxt = level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign wr_entry = {din.last, din.data};
  assign dout.valid = level != '0;
  assign dout.data = rd_entry.data;
  assign dout.last = rd_entry.last;
  lwc_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk(clk),
    .rst(rst),
    .we(push),
    .waddr(wr_ptr),
    .wdata(wr_entry),
    .raddr(rd_ptr),
    .rdata(rd_entry)
  );
  // DEPTH is a power of two, so pointers wrap naturally at AW bits.
  // ready looks at next-state level so a push that fills the FIFO blocks the following cycle.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      msg_cnt <= '0;
      din.ready <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      level <= level_nxt;
      msg_cnt <= msg_cnt + 8'(pop & dout.last);
      din.ready <= level_nxt < (AW+1)'(DEPTH);
    end
`ifdef LWC_DO_STATUS_CHK_EN
  logic done;
  assign done = pop & dout.last;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      auth_ok <= 1'b0;
      auth_fail <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      auth_ok <= done & (dout.data == STATUS_SUCCESS);
      auth_fail <= done & (dout.data == STATUS_FAILURE);
      proto_err <= done & (dout.data != STATUS_SUCCESS) & (dout.data != STATUS_FAILURE);
    end
`else
  assign auth_ok = 1'b0;
  assign auth_fail = 1'b0;
  assign proto_err = 1'b0;
`endif
endmodule

// File: tb/tb_lwc_do_buffer.sv
// tb_lwc_do_buffer: scoreboard bench for lwc_do_buffer (directed vectors, queue-based monitor)
module tb_lwc_do_buffer;
  import lwc_api_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] level;
  logic [7:0] msg_cnt;
  logic auth_ok, auth_fail, proto_err;
  int vectors = 0;
  int errors = 0;
  int ok_seen = 0, fail_seen = 0, err_seen = 0;
  entry_t exp_q[$];
  entry_t e;
  logic [2:0] pend = '0;
  logic done = 1'b0;

  lwc_do_buffer_if din();
  lwc_do_buffer_if dout();

  lwc_do_buffer #(.DEPTH(16), .AW(4)) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .dout(dout),
    .level(level),
    .msg_cnt(msg_cnt),
    .auth_ok(auth_ok),
    .auth_fail(auth_fail),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: samples 2 time units after each falling edge, pops the scoreboard on every
  // handshake and checks the status pulse expected from the previous completed message.
  always @(negedge clk) begin
    #2;
    if (!rst) pend = '0;
    else begin
      check("status_pulse", {29'd0, auth_ok, auth_fail, proto_err}, {29'd0, pend});
      ok_seen += int'(auth_ok);
      fail_seen += int'(auth_fail);
      err_seen += int'(proto_err);
      pend = '0;
      if (level > 5'd16) begin
        errors++;
        $display("FAIL level_bound: got %0d expected <= 16", level);
      end
      if (dout.valid && dout.ready) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pop: got %0h expected nothing", {dout.last, dout.data});
        end else begin
          e = exp_q.pop_front();
          check("out_byte", {23'd0, dout.last, dout.data}, {23'd0, e});
`ifdef LWC_DO_STATUS_CHK_EN
          if (e.last) pend = (e.data == 8'hE0) ? 3'b100 : (e.data == 8'hF0) ? 3'b010 : 3'b001;
`endif
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic l);
    int t = 0;
    din.valid = 1'b1;
    din.data = d;
    din.last = l;
    while (!din.ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!din.ready) begin
      errors++;
      $display("FAIL send_timeout: got no ready for byte %0h expected ready", d);
    end else begin
      exp_q.push_back({l, d});
      @(posedge clk);
      @(negedge clk);
    end
    din.valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    dout.ready = 1'b1;
    while (level != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    check("drain_level", 32'(level), 0);
    check("drain_queue", exp_q.size(), 0);
    dout.ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    din.valid = 1'b0;
    din.data = '0;
    din.last = 1'b0;
    dout.ready = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_level", 32'(level), 0);
    check("reset_valid", 32'(dout.valid), 0);
    check("reset_last", 32'(dout.last), 0);
    check("reset_data", 32'(dout.data), 0);
    check("reset_ready", 32'(din.ready), 0);
    check("reset_msg_cnt", 32'(msg_cnt), 0);
    rst = 1'b1;
    check("ready_before_edge", 32'(din.ready), 0);
    @(negedge clk);
    check("ready_after_release", 32'(din.ready), 1);

    // 1: mid-stream reset with 5 bytes stored
    for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i), 1'b0);
    check("t1_level5", 32'(level), 5);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("t1_rst_level", 32'(level), 0);
    check("t1_rst_valid", 32'(dout.valid), 0);
    check("t1_rst_msg_cnt", 32'(msg_cnt), 0);
    check("t1_rst_ready", 32'(din.ready), 0);
    @(negedge clk);
    rst = 1'b1;
    check("t1_ready_held", 32'(din.ready), 0);
    @(negedge clk);
    check("t1_ready_rise", 32'(din.ready), 1);
    check("t1_level_after", 32'(level), 0);

    // 2: pass-through with one-cycle latency
    dout.ready = 1'b1;
    send(8'h11, 1'b0);
    check("t2_latency_valid", 32'(dout.valid), 1);
    check("t2_latency_data", 32'(dout.data), 32'h11);
    send(8'h22, 1'b0);
    send(8'h33, 1'b1);
    drain();
    check("t2_msg_cnt", 32'(msg_cnt), 1);

    // 3: full, 17th byte waits for one pop
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    check("t3_level_full", 32'(level), 16);
    check("t3_ready_full", 32'(din.ready), 0);
    fork
      send(8'h77, 1'b1);
      begin
        repeat (3) @(negedge clk);
        check("t3_held_level", 32'(level), 16);
        check("t3_held_ready", 32'(din.ready), 0);
        dout.ready = 1'b1;
        @(negedge clk);
        dout.ready = 1'b0;
        check("t3_after_pop", 32'(level), 15);
      end
    join
    check("t3_refilled", 32'(level), 16);
    drain();
    check("t3_msg_cnt", 32'(msg_cnt), 2);

    // 4: 40 bytes with random sink back-pressure, across pointer wrap
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) send(8'(i * 7 + 3), i % 10 == 9);
        done = 1'b1;
      end
      while (!done) begin
        @(negedge clk);
        dout.ready = 1'($urandom_range(0, 1));
      end
    join
    drain();
    check("t4_msg_cnt", 32'(msg_cnt), 6);

    // 5: simultaneous push and pop at level 1 and at full
    send(8'h55, 1'b0);
    check("t5_level1", 32'(level), 1);
    dout.ready = 1'b1;
    send(8'h66, 1'b0);
    dout.ready = 1'b0;
    check("t5_level_hold", 32'(level), 1);
    check("t5_head", 32'(dout.data), 32'h66);
    for (int i = 0; i < 15; i++) send(8'hC0 + 8'(i), 1'b0);
    check("t5_full", 32'(level), 16);
    check("t5_full_ready", 32'(din.ready), 0);
    din.valid = 1'b1;
    din.data = 8'h99;
    din.last = 1'b0;
    dout.ready = 1'b1;
    @(negedge clk);
    din.valid = 1'b0;
    dout.ready = 1'b0;
    check("t5_refused_level", 32'(level), 15);
    check("t5_ready_back", 32'(din.ready), 1);
    drain();
    check("t5_msg_cnt", 32'(msg_cnt), 6);

    // 6: status decode
    ok_seen = 0;
    fail_seen = 0;
    err_seen = 0;
    dout.ready = 1'b1;
    send(8'h01, 1'b0);
    send(8'hE0, 1'b1);
    send(8'hF0, 1'b1);
    send(8'h5A, 1'b1);
    drain();
    check("t6_msg_cnt", 32'(msg_cnt), 9);
`ifdef LWC_DO_STATUS_CHK_EN
    check("t6_auth_ok", ok_seen, 1);
    check("t6_auth_fail", fail_seen, 1);
    check("t6_proto_err", err_seen, 1);
`else
    check("t6_auth_ok", ok_seen, 0);
    check("t6_auth_fail", fail_seen, 0);
    check("t6_proto_err", err_seen, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
